multi_channel_pulse_generator: RTL
==================================

// Module: multi_channel_pulse_generator
//
// PURPOSE
// Generalised edge-to-pulse converter: N_CH independent trigger inputs, each
// optionally synchronised, edge-detected per a selectable mode (rise/fall/both)
// and stretched into a registered output pulse of programmable length. Sits
// between external or cross-block trigger lines and the RAM/GA control logic,
// which consumes one clean pulse per trigger event.
//
// PARAMETERS
// N_CH         4   number of independent trigger channels
// CNT_W        8   width of pulse-length counter and pulse_len input
// SYNC_STAGES  2   synchroniser flops per channel (0 = bypass, input used directly)
// RETRIG       0   0: edges during an active pulse are ignored and flagged; 1: they restart the pulse
//
// PORTS
// clk         in   1          system clock, all logic on rising edge
// reset_x     in   1          asynchronous reset, active-high
// clk_enable  in   1          global enable; 0 = every register holds its value
// trig_in     in   N_CH       raw trigger inputs, bit i = channel i
// mode        in   2          00 rise, 01 fall, 10 both edges, 11 channels disabled
// pulse_len   in   CNT_W      pulse length in cycles; 0 is treated as 1
// clr_ovf     in   1          one-cycle clear of all overrun flags
// ce_out      out  1          equals clk_enable (combinational pass-through)
// pulse_out   out  N_CH       registered output pulses
// busy        out  N_CH       high while the channel's pulse is active (same as pulse_out)
// ovf         out  N_CH       sticky flag: edge was dropped while pulse was active
//
// BEHAVIOUR
// - Reset (async, reset_x=1): sync chain, prev-level reg, counters, pulse_out, ovf all 0.
// - Prev-level resets to 0: an input already high at reset release is a rising edge.
// - clk_enable=0: no register updates (sync, prev, counters, ovf); outputs hold.
// - Per channel: s = trig_in after SYNC_STAGES flops; prev <= s each enabled cycle.
//   rise = s & ~prev; fall = ~s & prev; edge per mode; mode 11 -> edge never true.
// - Per-channel FSM IDLE/PULSE. L = (pulse_len==0) ? 1 : pulse_len, sampled at pulse start.
//   IDLE + edge -> PULSE, cnt <= L, pulse_out <= 1.
//   PULSE: cnt decrements each enabled cycle; at cnt==1 with no retrigger -> IDLE, pulse_out <= 0.
// - Latency: with t0 = first clk edge sampling the new trig level, pulse_out rises
//   just after edge t0+SYNC_STAGES and stays high exactly L enabled cycles.
// - Edge while PULSE (including final cycle):
//   RETRIG=1: cnt reloads to current L; pulse extended with no low gap; ovf unchanged.
//   RETRIG=0: edge dropped, pulse unchanged, ovf[i] <= 1.
// - Back-to-back: edge on the first IDLE cycle after a pulse starts a new pulse;
//   minimum low gap between pulses is 1 cycle (RETRIG=0).
// - clr_ovf and overrun in same cycle: set wins, ovf stays 1.
// - mode/pulse_len changes affect only new edges; active pulses finish unchanged
//   (except RETRIG=1 reload uses the new pulse_len).
// - Channels fully independent; simultaneous edges on all channels all accepted.
// - Reset mid-pulse: pulse_out drops to 0 immediately, no residual pulse after release.
// - CNT_W bits of cnt must cover 2^CNT_W-1; no wrap; counter never underflows below 0.
//
// TESTING
// 1. SYNC_STAGES=2, mode=00, pulse_len=3, ch0 0->1 at t0 -> pulse_out[0] high cycles t0+3..t0+5, low after.
// 2. mode=01, ch1 1->0 -> single pulse; 0->1 on ch1 -> no pulse; mode=10 -> pulse on both edges.
// 3. RETRIG=0, pulse_len=5, second ch2 rise 2 cycles into pulse -> pulse still 5 cycles, ovf[2]=1; clr_ovf -> 0.
// 4. RETRIG=1, same stimulus -> pulse_out[2] high 7 cycles contiguous, ovf[2]=0.
// 5. pulse_len=0 -> 1-cycle pulses; clk_enable low 3 cycles mid-pulse -> pulse lengthened by 3, ce_out tracks.
// 6. trig_in high through reset, reset_x 1->0 -> one pulse (mode 00); reset asserted mid-pulse -> pulse_out=0 at once.

Source files
------------

// File: rtl/multi_channel_pulse_generator.sv
// Multi-channel edge-to-pulse converter: per-channel synchroniser, selectable
// edge detection and a programmable-length registered pulse with overrun flag.
module multi_channel_pulse_generator #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RETRIG      = 0
) (
    input  logic             clk,
    input  logic             reset_x,
    input  logic             clk_enable,
    input  logic [N_CH-1:0]  trig_in,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic             clr_ovf,
    output logic             ce_out,
    output logic [N_CH-1:0]  pulse_out,
    output logic [N_CH-1:0]  busy,
    output logic [N_CH-1:0]  ovf
);

    typedef enum logic {
        ST_IDLE,
        ST_PULSE
    } state_t;

    logic [N_CH-1:0]  sync_s;
    logic [N_CH-1:0]  prev_q;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_CH-1:0]  edge_det;
    logic [CNT_W-1:0] len_eff;

    if (SYNC_STAGES > 0) begin : g_sync
        logic [N_CH-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk or posedge reset_x) begin
            if (reset_x) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= '0;
                end
            end else if (clk_enable) begin
                sync_q[0] <= trig_in;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end
            end
        end

        assign sync_s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign sync_s = trig_in;
    end

    // prev starts at 0 so a line already high at reset release counts as a rise
    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            prev_q <= '0;
        end else if (clk_enable) begin
            prev_q <= sync_s;
        end
    end

    assign rise = sync_s & ~prev_q;
    assign fall = ~sync_s & prev_q;

    always_comb begin
        edge_det = '0;
        case (mode)
            2'b00:   edge_det = rise;
            2'b01:   edge_det = fall;
            2'b10:   edge_det = rise | fall;
            default: edge_det = '0;
        endcase
    end

    assign len_eff = (pulse_len == '0) ? CNT_W'(1) : pulse_len;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             ovf_q;
        logic             ovf_d;
        logic             pulse_bit;

        always_ff @(posedge clk or posedge reset_x) begin
            if (reset_x) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else if (clk_enable) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
            end
        end

        // an overrun in the same cycle as clr_ovf leaves the flag set
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ovf_d   = ovf_q & ~clr_ovf;
            case (state_q)
                ST_IDLE: begin
                    if (edge_det[i]) begin
                        state_d = ST_PULSE;
                        cnt_d   = len_eff;
                    end
                end
                ST_PULSE: begin
                    if (edge_det[i] && (RETRIG != 0)) begin
                        cnt_d = len_eff;
                    end else begin
                        if (edge_det[i]) begin
                            ovf_d = 1'b1;
                        end
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            pulse_bit = (state_q == ST_PULSE);
        end

        assign pulse_out[i] = pulse_bit;
        assign ovf[i]       = ovf_q;
    end

    assign busy   = pulse_out;
    assign ce_out = clk_enable;

endmodule
